// File: rtl/gol_frame_reader.sv
// Readout stage for the game-of-life array: snapshots `cells` after each update/snap
// request and streams the frame row by row over valid/ready. Optional GOL_FRAME_POPCOUNT_EN adds out_pop.
module gol_frame_reader #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      update,
  input  logic                      snap,
  input  logic [WIDTH*HEIGHT-1:0]   cells,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(HEIGHT)-1:0] out_row,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               frame_gen,
  output logic [7:0]                drop_cnt,
  output logic                      busy
`ifdef GOL_FRAME_POPCOUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] out_pop
`endif
);

  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state, state_next;
  logic                      pending;
  logic [15:0]               gen_cnt;
  logic [WIDTH*HEIGHT-1:0]   snapshot;
  logic                      req;
  logic                      capture;
  logic                      advance;
  logic [ROW_W-1:0]          next_row;
  logic [WIDTH-1:0]          next_data;

  assign req       = update | snap;
  assign capture   = (state == IDLE) && pending;
  assign advance   = (state == SEND) && out_ready && (out_row != ROW_LAST);
  assign next_row  = out_row + 1'b1;
  assign next_data = snapshot[next_row*WIDTH +: WIDTH];

  // Valid and last come only from registers, so out_ready never reaches them combinationally.
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (out_row == ROW_LAST);
  assign busy      = out_valid || pending;

`ifdef GOL_FRAME_POPCOUNT_EN
  localparam int POP_W = $clog2(WIDTH + 1);

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) sum = sum + POP_W'(v[i]);
    return sum;
  endfunction
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path through this block can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pending) state_next = SEND;
      SEND: if (out_ready && out_row == ROW_LAST) state_next = IDLE;
    endcase
  end

  // NOTE: the snapshot is reset along with everything else; it is only one frame of flops
  // and a clean reset keeps out_data deterministic after a mid-frame abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      gen_cnt   <= '0;
      snapshot  <= '0;
      out_data  <= '0;
      out_row   <= '0;
      frame_gen <= '0;
      drop_cnt  <= '0;
`ifdef GOL_FRAME_POPCOUNT_EN
      out_pop   <= '0;
`endif
    end else begin
      if (update) gen_cnt <= gen_cnt + 16'd1;

      if (capture) begin
        // A request landing on the capture edge re-arms pending rather than counting as a drop.
        pending   <= req;
        snapshot  <= cells;
        frame_gen <= gen_cnt;
        out_row   <= '0;
        out_data  <= cells[WIDTH-1:0];
`ifdef GOL_FRAME_POPCOUNT_EN
        out_pop   <= popcount(cells[WIDTH-1:0]);
`endif
      end else begin
        if (req) begin
          pending <= 1'b1;
          if (pending && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        if (advance) begin
          out_row  <= next_row;
          out_data <= next_data;
`ifdef GOL_FRAME_POPCOUNT_EN
          out_pop  <= popcount(next_data);
`endif
        end
      end
    end
  end

endmodule
